// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory BIST sequencer with a pipelined read checker.
// Drives one single-port memory through six March C- elements (w0 / r0,w1 / r1,w0 /
// down r0,w1 / down r1,w0 / r0) and reports pass/fail with the first failing
// address and element.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             one-cycle run request (ignored while busy)
//   mem_write_read    1 = write, 0 = read
//   mem_address       memory address (0 outside the run phase)
//   mem_wdata         data of the write issued in the following cycle
//   mem_rdata         read data, valid two cycles after the read is issued
//   busy, done        run in progress / run finished (sticky)
//   fail              mismatch seen (sticky)
//   fail_addr         address of the first mismatch
//   fail_elem         element index (0..5) of the first mismatch
//   err_count         mismatch count, saturating at 255
//
// Configuration macro: MBIST_ERR_COUNT_EN
//   defined   : the full sequence always runs and err_count counts mismatches
//   undefined : fail-stop on the first mismatch, err_count is tied to 0
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [7:0]            err_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CAPACITY);
    localparam logic [2:0]            ELEM_LAST = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Element 0 is w0 only, element 5 is r0 only; the rest are a read
    // followed by a write of the complementary background.
    function automatic logic single_op(input logic [2:0] e);
        return (e == 3'd0) || (e == 3'd5);
    endfunction

    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic op_wr(input logic [2:0] e, input logic s);
        return (e == 3'd0) || ((e != 3'd5) && s);
    endfunction

    // Background bit of an op: the expected value for a read, the written
    // value for a write.
    function automatic logic op_bit(input logic [2:0] e, input logic s);
        logic b;
        b = 1'b0;
        if ((e == 3'd1) || (e == 3'd3)) b = s;
        if ((e == 3'd2) || (e == 3'd4)) b = ~s;
        return b;
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  sub_q, sub_d;
    logic                  drain_q, drain_d;

    logic [2:0]            adv_elem;
    logic [ADDR_WIDTH-1:0] adv_addr;
    logic                  adv_sub;
    logic                  last_op;
    logic                  sub_end;
    logic                  addr_end;

    logic                  start_run;
    logic                  stop;
    logic                  run;
    logic                  cmp_en;
    logic                  hit;
    logic                  first;

    logic                  p1_v_q, p2_v_q;
    logic                  p1_exp_q, p2_exp_q;
    logic [ADDR_WIDTH-1:0] p1_addr_q, p2_addr_q;
    logic [2:0]            p1_elem_q, p2_elem_q;

    logic                  fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [2:0]            fail_elem_q;

    logic                  nxt_vld;
    logic                  nxt_bit;

    assign run    = (state_q == S_RUN);
    assign cmp_en = (state_q == S_RUN) || (state_q == S_DRAIN);

    // Successor of the op currently presented.
    always_comb begin
        adv_elem = elem_q;
        adv_addr = addr_q;
        adv_sub  = 1'b0;
        last_op  = 1'b0;
        sub_end  = single_op(elem_q) || sub_q;
        addr_end = is_down(elem_q) ? (addr_q == '0) : (addr_q == LAST);
        if (!sub_end) begin
            adv_sub = 1'b1;
        end else if (!addr_end) begin
            adv_addr = is_down(elem_q) ? addr_q - ADDR_WIDTH'(1)
                                       : addr_q + ADDR_WIDTH'(1);
        end else if (elem_q == ELEM_LAST) begin
            last_op = 1'b1;
        end else begin
            adv_elem = elem_q + 3'd1;
            adv_addr = is_down(elem_q + 3'd1) ? LAST : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        addr_d    = addr_q;
        sub_d     = sub_q;
        drain_d   = drain_q;
        start_run = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_PREP;
                    elem_d    = 3'd0;
                    addr_d    = '0;
                    sub_d     = 1'b0;
                    start_run = 1'b1;
                end
            end
            S_PREP: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (last_op) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    elem_d = adv_elem;
                    addr_d = adv_addr;
                    sub_d  = adv_sub;
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (stop) state_d = S_DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            elem_q  <= 3'd0;
            addr_q  <= '0;
            sub_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            sub_q   <= sub_d;
            drain_q <= drain_d;
        end
    end

    // Memory bus. Write data runs one op ahead: in PREP the upcoming op is
    // the one already loaded, during RUN it is the successor.
    always_comb begin
        nxt_vld = 1'b0;
        nxt_bit = 1'b0;
        if (state_q == S_PREP) begin
            nxt_vld = 1'b1;
            nxt_bit = op_bit(elem_q, sub_q);
        end else if (run && !last_op) begin
            nxt_vld = 1'b1;
            nxt_bit = op_bit(adv_elem, adv_sub);
        end
    end

    assign mem_write_read = run && op_wr(elem_q, sub_q);
    assign mem_address    = run ? addr_q : '0;
    assign mem_wdata      = nxt_vld ? {DATA_WIDTH{nxt_bit}} : '0;

    // Checker pipeline: two stages match the memory read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_v_q    <= 1'b0;
            p1_exp_q  <= 1'b0;
            p1_addr_q <= '0;
            p1_elem_q <= 3'd0;
            p2_v_q    <= 1'b0;
            p2_exp_q  <= 1'b0;
            p2_addr_q <= '0;
            p2_elem_q <= 3'd0;
        end else if (start_run || stop) begin
            p1_v_q <= 1'b0;
            p2_v_q <= 1'b0;
        end else begin
            p1_v_q    <= run && !op_wr(elem_q, sub_q);
            p1_exp_q  <= op_bit(elem_q, sub_q);
            p1_addr_q <= addr_q;
            p1_elem_q <= elem_q;
            p2_v_q    <= p1_v_q;
            p2_exp_q  <= p1_exp_q;
            p2_addr_q <= p1_addr_q;
            p2_elem_q <= p1_elem_q;
        end
    end

    assign hit   = cmp_en && p2_v_q && (mem_rdata != {DATA_WIDTH{p2_exp_q}});
    assign first = hit && !fail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
        end else if (start_run) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
        end else if (first) begin
            fail_q      <= 1'b1;
            fail_addr_q <= p2_addr_q;
            fail_elem_q <= p2_elem_q;
        end
    end

`ifdef MBIST_ERR_COUNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 8'd0;
        end else if (start_run) begin
            err_q <= 8'd0;
        end else if (hit && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign stop      = 1'b0;
    assign err_count = err_q;
`else
    // Fail-stop: the edge that records the first mismatch also ends the run.
    assign stop      = first;
    assign err_count = 8'd0;
`endif

    assign busy      = (state_q == S_PREP) || run || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: scoreboard bench for mbist_march_ctrl.
// Expected op stream and fault outcome come from a March C- model over a faultable memory.
module tb_mbist_march_ctrl;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int CAP  = 15;
    localparam int N    = CAP + 1;
    localparam int NOPS = 10 * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mem_write_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [7:0]    err_count;

    int errors = 0;
    int checks = 0;

    int   fmode = 0;
    logic mem_clr = 1'b0;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] wd_q;
    logic [DW-1:0] rd1_q;

    logic [DW+AW:0] exp_q [$];
    int exp_k;
    int exp_elem;
    int exp_addr;
    int exp_errs;

    always #5 clk = ~clk;

    mbist_march_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CAPACITY  (CAP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mem_write_read(mem_write_read),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .fail_addr     (fail_addr),
        .fail_elem     (fail_elem),
        .err_count     (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // fmode 1: a write that drops bit 4 of address 5 inverts bit 3.
    // fmode 2: bit 0 of address 0 is stuck at 0.
    function automatic logic [DW-1:0] inject(input int a, input logic [DW-1:0] old,
                                             input logic [DW-1:0] nv);
        logic [DW-1:0] v;
        v = nv;
        if (fmode == 1 && a == 5 && old[4] && !nv[4]) v[3] = ~v[3];
        if (fmode == 2 && a == 0) v[0] = 1'b0;
        return v;
    endfunction

    // Memory under test: wdata registered one cycle, two-cycle read latency.
    always @(posedge clk) begin
        wd_q      <= mem_wdata;
        rd1_q     <= mem[mem_address];
        mem_rdata <= rd1_q;
        if (mem_clr) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (mem_write_read) begin
            mem[mem_address] <= inject(int'(mem_address), mem[mem_address], wd_q);
        end
    end

    task automatic build();
        logic [DW-1:0] gm [N];
        logic [DW-1:0] pat;
        bit dn;
        bit wr;
        bit b;
        int ns;
        int a;
        int k;
        exp_q.delete();
        exp_k    = -1;
        exp_elem = 0;
        exp_addr = 0;
        exp_errs = 0;
        k        = 0;
        for (int i = 0; i < N; i++) gm[i] = '0;
        for (int e = 0; e < 6; e++) begin
            dn = (e == 3 || e == 4);
            ns = (e == 0 || e == 5) ? 1 : 2;
            for (int j = 0; j < N; j++) begin
                a = dn ? CAP - j : j;
                for (int s = 0; s < ns; s++) begin
                    wr = (e == 0) || (e != 5 && s == 1);
                    if (e == 1 || e == 3) b = (s == 1);
                    else if (e == 2 || e == 4) b = (s == 0);
                    else b = 1'b0;
                    pat = {DW{b}};
                    if (wr) begin
                        gm[a] = inject(a, gm[a], pat);
                        exp_q.push_back({1'b1, AW'(a), pat});
                    end else begin
                        exp_q.push_back({1'b0, AW'(a), {DW{1'b0}}});
                        if (gm[a] != pat) begin
                            if (exp_k < 0) begin
                                exp_k    = k;
                                exp_elem = e;
                                exp_addr = a;
                            end
                            if (exp_errs < 255) exp_errs++;
                        end
                    end
                    k++;
                end
            end
        end
    endtask

    task automatic run(input int mode, input bit restart, input int rst_at);
        int done_i;
        int n_ops;
        int exp_done;
        int writes;
        logic [DW-1:0]  prev_wd;
        logic [DW+AW:0] exp_op;
        logic [DW+AW:0] got_op;
        fmode = mode;
        build();
`ifdef MBIST_ERR_COUNT_EN
        n_ops    = NOPS;
        exp_done = NOPS + 3;
`else
        n_ops    = (exp_k < 0) ? NOPS : exp_k + 3;
        exp_done = (exp_k < 0) ? NOPS + 3 : exp_k + 4;
`endif
        @(negedge clk);
        mem_clr = 1'b1;
        @(negedge clk);
        mem_clr = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("prep_busy", busy, 1);
        check("prep_clr", {done, fail, fail_addr, fail_elem, err_count}, 0);
        check("prep_wr", mem_write_read, 0);
        prev_wd = mem_wdata;
        done_i  = -1;
        writes  = 0;
        for (int i = 1; i <= 400 && done_i < 0; i++) begin
            @(negedge clk);
            if (i <= n_ops && exp_q.size() > 0) begin
                exp_op = exp_q.pop_front();
                got_op = {mem_write_read, mem_address,
                          mem_write_read ? prev_wd : {DW{1'b0}}};
                check("op", got_op, exp_op);
                if (mem_write_read) writes++;
            end
            prev_wd = mem_wdata;
            if (restart && i == 20) start = 1'b1;
            if (restart && i == 21) start = 1'b0;
            if (rst_at > 0 && i == rst_at + 1) begin
                rst = 1'b1;
                #1;
                check("rst_mid", {busy, done, fail, mem_write_read, mem_address,
                                  mem_wdata, fail_addr, fail_elem, err_count}, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done) done_i = i;
        end
        check("done_at", done_i, exp_done);
        check("busy_end", busy, 0);
        check("idle_bus", {mem_write_read, mem_address}, 0);
        check("fail", fail, (exp_k >= 0));
        check("fail_addr", fail_addr, (exp_k >= 0) ? exp_addr : 0);
        check("fail_elem", fail_elem, (exp_k >= 0) ? exp_elem : 0);
`ifdef MBIST_ERR_COUNT_EN
        check("err_count", err_count, exp_errs);
        check("writes", writes, NOPS / 2);
`else
        check("err_count", err_count, 0);
        if (exp_k < 0) check("writes", writes, NOPS / 2);
`endif
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_faddr", fail_addr, 0);
        check("rst_felem", fail_elem, 0);
        check("rst_errs", err_count, 0);
        check("rst_wr", mem_write_read, 0);
        check("rst_addr", mem_address, 0);
        check("rst_wdata", mem_wdata, 0);
        rst = 1'b0;
        run(0, 1'b0, 0);
        run(0, 1'b1, 0);
        run(1, 1'b0, 0);
        run(2, 1'b0, 0);
        run(0, 1'b0, 50);
        run(0, 1'b0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
